// File: rtl/regf_apb_bridge.sv
// regf_apb_bridge: APB4 completer driving the mem_* port of a generated regf.
// Define REGF_APB_RMW_EN to turn partial-strobe writes into read-modify-write.
module regf_apb_bridge #(
  parameter int PADDRW = 16,
  parameter int ADDRW  = 13,
  parameter int DATAW  = 32
) (
  input  logic              main_clk_i,
  input  logic              main_rst_an_i,
  input  logic              apb_psel_i,
  input  logic              apb_penable_i,
  input  logic              apb_pwrite_i,
  input  logic [PADDRW-1:0] apb_paddr_i,
  input  logic [DATAW-1:0]  apb_pwdata_i,
  input  logic [DATAW/8-1:0] apb_pstrb_i,
  output logic [DATAW-1:0]  apb_prdata_o,
  output logic              apb_pready_o,
  output logic              apb_pslverr_o,
  output logic              mem_ena_o,
  output logic [ADDRW-1:0]  mem_addr_o,
  output logic              mem_wena_o,
  output logic [DATAW-1:0]  mem_wdata_o,
  input  logic [DATAW-1:0]  mem_rdata_i,
  input  logic              mem_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    RMW_RD,
    ACCESS,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic [DATAW-1:0] prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic             mem_ena_q, mem_ena_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic             mem_wena_q, mem_wena_d;
  logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;

  logic setup;
  logic bad_addr;
  logic zero_strb;
  logic partial;
  logic reject;

  assign setup     = apb_psel_i & ~apb_penable_i;
  assign bad_addr  = (apb_paddr_i[1:0] != 2'b00)
                   | (|apb_paddr_i[PADDRW-1:ADDRW]);
  assign zero_strb = apb_pwrite_i & (apb_pstrb_i == '0);
  assign partial   = apb_pwrite_i & (apb_pstrb_i != '1);

`ifdef REGF_APB_RMW_EN
  logic [DATAW-1:0]   wdata_q, wdata_d;
  logic [DATAW/8-1:0] strb_q, strb_d;
  logic [DATAW-1:0]   merged;

  assign reject = bad_addr | zero_strb;

  // Overlay strobed write bytes onto the word just read from the regf.
  always_comb begin
    merged = mem_rdata_i;
    for (int i = 0; i < DATAW / 8; i++) begin
      if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
`else
  assign reject = bad_addr | zero_strb | partial;
`endif

  // Next state plus next value of every registered output.
  // Rejected transfers still pass through ACCESS (with no mem strobe)
  // so that every single-access transfer has the same one wait state.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    err_d       = err_q;
    prdata_d    = '0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    mem_ena_d   = 1'b0;
    mem_wena_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef REGF_APB_RMW_EN
    wdata_d     = wdata_q;
    strb_d      = strb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          wr_d    = apb_pwrite_i;
          state_d = ACCESS;
          if (reject) begin
            err_d = 1'b1;
`ifdef REGF_APB_RMW_EN
          end else if (partial) begin
            err_d      = 1'b0;
            state_d    = RMW_RD;
            mem_ena_d  = 1'b1;
            mem_addr_d = {apb_paddr_i[ADDRW-1:2], 2'b00};
            wdata_d    = apb_pwdata_i;
            strb_d     = apb_pstrb_i;
`endif
          end else begin
            err_d      = 1'b0;
            mem_ena_d  = 1'b1;
            mem_wena_d = apb_pwrite_i;
            mem_addr_d = {apb_paddr_i[ADDRW-1:2], 2'b00};
            if (apb_pwrite_i) mem_wdata_d = apb_pwdata_i;
          end
        end
      end
`ifdef REGF_APB_RMW_EN
      RMW_RD: begin
        if (mem_err_i) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          state_d     = ACCESS;
          mem_ena_d   = 1'b1;
          mem_wena_d  = 1'b1;
          mem_wdata_d = merged;
        end
      end
`endif
      ACCESS: begin
        state_d   = RESP;
        pready_d  = 1'b1;
        pslverr_d = err_q | (mem_ena_q & mem_err_i);
        if (!wr_q && !pslverr_d) prdata_d = mem_rdata_i;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      mem_ena_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wena_q  <= 1'b0;
      mem_wdata_q <= '0;
`ifdef REGF_APB_RMW_EN
      wdata_q     <= '0;
      strb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      mem_ena_q   <= mem_ena_d;
      mem_addr_q  <= mem_addr_d;
      mem_wena_q  <= mem_wena_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef REGF_APB_RMW_EN
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
`endif
    end
  end

  assign apb_prdata_o  = prdata_q;
  assign apb_pready_o  = pready_q;
  assign apb_pslverr_o = pslverr_q;
  assign mem_ena_o     = mem_ena_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wena_o    = mem_wena_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
